// File: rtl/am_pkg.sv
// rtl/am_pkg.sv - shared alignment marker constants, lane FSM states and matcher
package am_pkg;

  localparam int AM_PERIOD_W = 14;
  localparam int AM_LANES    = 4;
  localparam int AM_ID_W     = 2;

  // Sync header carried by every control block, markers included.
  localparam logic [1:0] AM_HEAD = 2'b10;

  // Bytes 3 and 7 carry BIP3/BIP7 and are don't-care when matching.
  localparam logic [63:0] AM_CARE = 64'h00FF_FFFF_00FF_FFFF;

  // Marker payloads with byte 0 at [7:0]; BIP positions are zero here.
  localparam logic [3:0][63:0] AM_MARKER = {
    64'h00C2_865D_003D_79A2,  // L3
    64'h0064_9A3A_009B_65C5,  // L2
    64'h0019_3B0F_00E6_C4F0,  // L1
    64'h00B8_896F_0047_7690   // L0
  };

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } lane_state_t;

  typedef struct packed {
    logic               hit;
    logic [AM_ID_W-1:0] id;
  } am_match_t;

  // Encodings are mutually exclusive, so at most one lane ID can hit.
  function automatic am_match_t am_match(input logic [1:0] head, input logic [63:0] data);
    am_match_t r;
    r = '0;
    if (head == AM_HEAD) begin
      for (int k = 0; k < AM_LANES; k++) begin
        if ((data & AM_CARE) == AM_MARKER[k]) begin
          r.hit = 1'b1;
          r.id  = AM_ID_W'(k);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/am_lane_rx.sv
// rtl/am_lane_rx.sv - per-lane marker match, period tracking, lock FSM and output register
module am_lane_rx #(
  parameter int HEAD_W      = 2,
  parameter int DATA_W      = 64,
  parameter int AM_PERIOD_W = am_pkg::AM_PERIOD_W,
  parameter int MISS_MAX    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o,
  output logic              marker_v_o,
  output logic              lock_o,
  output logic [1:0]        lane_id_o,
  output logic              lock_nxt_o,
  output logic [1:0]        id_nxt_o
);
  import am_pkg::*;

  lane_state_t            state_q, state_d;
  logic [AM_PERIOD_W-1:0] cnt_q, cnt_d;
  logic [2:0]             miss_q, miss_d;
  logic [1:0]             id_q, id_d;
  logic                   mark_q, mark_d;
  logic                   lock_q;
  logic                   valid_q;
  logic [HEAD_W-1:0]      head_q;
  logic [DATA_W-1:0]      data_q;

  am_match_t              m;
  logic                   at_exp;
  logic                   good;

  assign m      = am_match(head_i, data_i);
  assign at_exp = valid_i && (cnt_q == {AM_PERIOD_W{1'b1}});
  assign good   = valid_i && m.hit && (m.id == id_q);

  // Next-state: search for any marker, confirm one period later, then police the period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    id_d    = id_q;
    mark_d  = 1'b0;
    if (valid_i) begin
      // The expected position wraps the counter to zero, which rearms the period.
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        ST_SEARCH: begin
          if (m.hit) begin
            id_d    = m.id;
            cnt_d   = '0;
            miss_d  = '0;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (at_exp) begin
            if (good) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
              mark_d  = 1'b1;
            end else begin
              state_d = ST_SEARCH;
            end
          end
        end
        ST_LOCKED: begin
          if (at_exp) begin
            mark_d = 1'b1;
            if (good) begin
              miss_d = '0;
            end else if (miss_q + 3'd1 == 3'(MISS_MAX)) begin
              miss_d  = '0;
              state_d = ST_SEARCH;
            end else begin
              miss_d = miss_q + 3'd1;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // State and output registers; status lines up with the block it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SEARCH;
      cnt_q   <= '0;
      miss_q  <= '0;
      id_q    <= '0;
      mark_q  <= 1'b0;
      lock_q  <= 1'b0;
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      id_q    <= id_d;
      mark_q  <= mark_d;
      lock_q  <= (state_d == ST_LOCKED);
      valid_q <= valid_i;
      head_q  <= head_i;
      data_q  <= data_i;
    end
  end

  assign valid_o    = valid_q;
  assign head_o     = head_q;
  assign data_o     = data_q;
  assign marker_v_o = mark_q;
  assign lock_o     = lock_q;
  assign lane_id_o  = id_q;
  assign lock_nxt_o = (state_d == ST_LOCKED);
  assign id_nxt_o   = id_d;

endmodule

// File: rtl/am_rx.sv
// rtl/am_rx.sv - 4-lane alignment marker receiver with aggregate lock and duplicate-ID check
module am_rx #(
  parameter int LANE_N      = 4,
  parameter int HEAD_W      = 2,
  parameter int DATA_W      = 64,
  parameter int AM_PERIOD_W = am_pkg::AM_PERIOD_W,
  parameter int MISS_MAX    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANE_N-1:0]        valid_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic [LANE_N-1:0]        valid_o,
  output logic [LANE_N*HEAD_W-1:0] head_o,
  output logic [LANE_N*DATA_W-1:0] data_o,
  output logic [LANE_N-1:0]        marker_v_o,
  output logic [LANE_N-1:0]        lock_o,
  output logic [LANE_N*2-1:0]      lane_id_o,
  output logic                     all_lock_o,
  output logic                     lane_err_o
);
  import am_pkg::*;

  logic [LANE_N-1:0]         lock_nxt;
  logic [LANE_N*AM_ID_W-1:0] id_nxt;
  logic                      err_d;
  logic                      err_q;
  logic                      all_q;

  for (genvar g = 0; g < LANE_N; g++) begin : g_lane
    am_lane_rx #(
      .HEAD_W      (HEAD_W),
      .DATA_W      (DATA_W),
      .AM_PERIOD_W (AM_PERIOD_W),
      .MISS_MAX    (MISS_MAX)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (valid_i[g]),
      .head_i     (head_i[g*HEAD_W +: HEAD_W]),
      .data_i     (data_i[g*DATA_W +: DATA_W]),
      .valid_o    (valid_o[g]),
      .head_o     (head_o[g*HEAD_W +: HEAD_W]),
      .data_o     (data_o[g*DATA_W +: DATA_W]),
      .marker_v_o (marker_v_o[g]),
      .lock_o     (lock_o[g]),
      .lane_id_o  (lane_id_o[g*2 +: 2]),
      .lock_nxt_o (lock_nxt[g]),
      .id_nxt_o   (id_nxt[g*AM_ID_W +: AM_ID_W])
    );
  end

  // Duplicate-ID check over every pair of lanes that will be locked next cycle.
  always_comb begin
    err_d = 1'b0;
    for (int a = 0; a < LANE_N; a++) begin
      for (int b = a + 1; b < LANE_N; b++) begin
        if (lock_nxt[a] && lock_nxt[b] &&
            (id_nxt[a*AM_ID_W +: AM_ID_W] == id_nxt[b*AM_ID_W +: AM_ID_W])) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Aggregate status registered so it updates together with the lane outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      all_q <= 1'b0;
    end else begin
      err_q <= err_d;
      all_q <= (&lock_nxt) && !err_d;
    end
  end

  assign lane_err_o = err_q;
  assign all_lock_o = all_q;

endmodule

// File: doc/am_rx.md
Name: am_rx

Overview:
- Receive-side alignment marker (AM) block for the 4-lane 64b/66b PCS, placed after per-lane block lock and before lane deskew/reorder.
- Each physical lane searches for any of the 4 lane marker encodings, locks to the 16384-block marker period, and reports the logical lane ID.
- Each marker block is flagged so downstream logic removes it. The block also reports aggregate lock and duplicate-lane errors.

Parameters:
- LANE_N, 4, number of physical lanes
- HEAD_W, 2, sync header width
- DATA_W, 64, block payload width
- AM_PERIOD_W, 14, log2 of the marker period in valid blocks; the period is 2^14 = 16384. Benches may reduce this value.
- MISS_MAX, 4, consecutive missed expected markers that force loss of lock

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_i  in  LANE_N  per-lane block valid from gearbox/block lock
- head_i  in  LANE_N*HEAD_W  per-lane sync header; lane i is at [i*HEAD_W +: HEAD_W]
- data_i  in  LANE_N*DATA_W  per-lane payload; byte 0 is data[7:0]
- valid_o  out  LANE_N  registered valid_i
- head_o  out  LANE_N*HEAD_W  registered head_i
- data_o  out  LANE_N*DATA_W  registered data_i
- marker_v_o  out  LANE_N  output block on lane i is an alignment marker; downstream drops it
- lock_o  out  LANE_N  per-lane AM lock
- lane_id_o  out  LANE_N*2  logical lane ID per physical lane; valid only while lock_o[i]=1
- all_lock_o  out  1  all lanes locked, and all lane IDs distinct
- lane_err_o  out  1  two or more locked lanes report the same ID

Behaviour:
- Latency: 1 cycle on all data-path outputs. Status outputs are registered and update in the same cycle as the corresponding data output.
- Reset values: valid_o=0, head_o=0, data_o=0, marker_v_o=0, lock_o=0, lane_id_o=0, all_lock_o=0, lane_err_o=0. Every lane FSM enters SEARCH and all counters clear. Reset mid-operation drops lock within 1 cycle.
- Marker match, combinational per lane and only when valid_i=1:
  - head == 2'b10.
  - Bytes 0,1,2,4,5,6 equal the lane-k encoding. Bytes 3 and 7 (BIP3/BIP7) are ignored.
  - Encodings, byte0..byte2 and byte4..byte6:
    - L0: 90 76 47 / 6F 89 B8
    - L1: F0 C4 E6 / 0F 3B 19
    - L2: C5 65 9B / 3A 9A 64
    - L3: A2 79 3D / 5D 86 C2
  - Output: hit (1 bit) and hit_id (2 bits). Encodings are mutually exclusive.
- Per-lane counters:
  - blk_cnt, AM_PERIOD_W bits. Increments only on valid_i. Cleared to 0 on the block that starts or rearms the period. Expected marker position is blk_cnt == 2^AM_PERIOD_W-1 with valid_i=1, i.e. 2^AM_PERIOD_W valid blocks after the previous marker.
  - miss_cnt, 3 bits.
  - Invalid cycles do not advance any state.
- Per-lane FSM:
  - SEARCH: on hit, capture id_q=hit_id, clear blk_cnt, go to CHECK. Otherwise stay.
  - CHECK: at the expected position, if hit and hit_id==id_q, go to LOCKED with miss_cnt=0. Otherwise go to SEARCH. A hit at a non-expected position is ignored.
  - LOCKED:
    - At the expected position with hit and matching id: miss_cnt=0.
    - At the expected position otherwise: miss_cnt+1. If the incremented value equals MISS_MAX, go to SEARCH and deassert lock_o on the next output.
    - Hits off the expected position are ignored and do not move the period.
- marker_v_o[i]=1 when the lane is LOCKED and the block is at its expected position, whether or not it matched. It is also 1 on the CHECK→LOCKED transition block. It is never 1 in SEARCH.
- lock_o[i]=1 in LOCKED, from the cycle after the second consecutive marker is accepted.
- all_lock_o = &lock_o and ~lane_err_o.
- lane_err_o is evaluated over all pairs of locked lanes.
- Lanes are fully independent. Skew between lanes is allowed; deskew happens downstream.

Decomposition:
- Shared package am_pkg:
  - AM_PERIOD_W
  - Marker byte constants per lane, with BIP byte positions marked don't-care
  - Header constant for control blocks (2'b10)
  - Lane FSM state enum: SEARCH, CHECK, LOCKED
  - The TX insertion block must use the same constants.
- Sub-module am_lane_rx: per-lane match, counters, FSM and output register.
- The top level instantiates LANE_N copies and adds the lane_err_o / all_lock_o logic.

Test Plan (bench uses AM_PERIOD_W=4):
- Reset, then 20 cycles of random non-marker blocks with valid_i=F → lock_o=0, marker_v_o=0, data_o equals data_i delayed 1 cycle.
- Lanes 0..3 carry L2, L0, L3, L1 markers every 16 valid blocks → lock_o=F after the second marker, lane_id_o={01,11,00,10}, all_lock_o=1, marker_v_o pulses once every 16 blocks per lane.
- Locked lane 0, with markers replaced by idle for 3 consecutive periods and then restored → lock held, miss_cnt returns to 0. Replaced for 4 periods → lock_o[0]=0 right after the 4th expected position, and all_lock_o=0.
- valid_i[1] deasserted for 5 random cycles between markers → lane 1 stays locked and the expected position slips by exactly the invalid cycles.
- Lanes 0 and 2 both carry the L1 marker → both lock, lane_err_o=1, all_lock_o=0.
- CHECK with the second marker carrying a different ID (L0 then L3), or arriving at count 15 versus 16 → returns to SEARCH, lock_o stays 0. Assert reset while LOCKED → all outputs are 0 on the next cycle.
